// File: rtl/mem_line_ctrl_if.sv
// rtl/mem_line_ctrl_if.sv - request/response bundle between the cache and the line memory controller
interface mem_line_ctrl_if #(
   parameter int ADDR_W = 10,
   parameter int LINE_W = 128,
   parameter int CNT_W  = 16
);
   logic              req_valid;
   logic              req_ready;
   logic              req_rw;
   logic [ADDR_W-1:0] req_addr;
   logic [LINE_W-1:0] req_wdata;
   logic              resp_valid;
   logic              resp_ready;
   logic [LINE_W-1:0] resp_rdata;
   logic [CNT_W-1:0]  rd_count;
   logic [CNT_W-1:0]  wr_count;

   modport master (
      output req_valid, req_rw, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, rd_count, wr_count
   );

   modport slave (
      input  req_valid, req_rw, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, rd_count, wr_count
   );
endinterface

// File: rtl/mem_line_ctrl.sv
// rtl/mem_line_ctrl.sv - fixed-latency 64 x 128-bit line memory with saturating access counters
module mem_line_ctrl #(
   parameter int ADDR_W  = 10,
   parameter int LINE_W  = 128,
   parameter int LINES   = 64,
   parameter int LATENCY = 4,
   parameter int CNT_W   = 16
) (
   input logic           clk,
   input logic           rst_n,
   mem_line_ctrl_if.slave bus
);
   localparam int IDX_W = ADDR_W - 4;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t            r_state;
   state_t            w_next;
   logic              r_live;
   logic              r_rw;
   logic [IDX_W-1:0]  r_idx;
   logic [LINE_W-1:0] r_wdata;
   logic [LINE_W-1:0] r_rdata;
   logic [3:0]        r_cnt;
   logic [CNT_W-1:0]  r_rd;
   logic [CNT_W-1:0]  r_wr;
   logic [LINE_W-1:0] r_mem [LINES];

   logic              w_ready;
   logic              w_accept;
   logic              w_access;
   logic              w_unused_ofs;

   // r_live keeps req_ready low until the first edge after reset release
   assign w_ready      = r_live && (r_state == IDLE);
   assign w_accept     = bus.req_valid && w_ready;
   assign w_access     = (r_state == WAIT) && (r_cnt == 4'd0);
   assign w_unused_ofs = ^bus.req_addr[3:0];

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_next = WAIT;
         WAIT:    if (r_cnt == 4'd0) w_next = RESP;
         RESP:    if (bus.resp_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_live  <= 1'b0;
         r_rw    <= 1'b0;
         r_idx   <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_cnt   <= '0;
         r_rd    <= '0;
         r_wr    <= '0;
      end else begin
         r_state <= w_next;
         r_live  <= 1'b1;
         if (w_accept) begin
            r_rw    <= bus.req_rw;
            r_idx   <= bus.req_addr[ADDR_W-1:4];
            r_wdata <= bus.req_wdata;
            r_cnt   <= 4'(LATENCY - 1);
            if (bus.req_rw) begin
               if (r_wr != '1) r_wr <= r_wr + CNT_W'(1);
            end else begin
               if (r_rd != '1) r_rd <= r_rd + CNT_W'(1);
            end
         end
         if ((r_state == WAIT) && (r_cnt != 4'd0)) r_cnt <= r_cnt - 4'd1;
         if (w_access) r_rdata <= r_rw ? r_wdata : r_mem[r_idx];
      end
   end

   // the write lands on the same edge the response becomes valid
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LINES; i++) r_mem[i] <= '0;
      end else if (w_access && r_rw) begin
         r_mem[r_idx] <= r_wdata;
      end
   end

   assign bus.req_ready  = w_ready;
   assign bus.resp_valid = (r_state == RESP);
   assign bus.resp_rdata = r_rdata;
   assign bus.rd_count   = r_rd;
   assign bus.wr_count   = r_wr;
endmodule

// File: tb/tb_mem_line_ctrl.sv
// tb/tb_mem_line_ctrl.sv - bench for mem_line_ctrl at LATENCY 4, 1 and 15
module tb_mem_line_ctrl;
   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_fail;

   mem_line_ctrl_if #(.ADDR_W(10), .LINE_W(128), .CNT_W(16)) b0 ();
   mem_line_ctrl_if #(.ADDR_W(10), .LINE_W(128), .CNT_W(3))  b1 ();
   mem_line_ctrl_if #(.ADDR_W(10), .LINE_W(128), .CNT_W(16)) b2 ();

   mem_line_ctrl #(.ADDR_W(10), .LINE_W(128), .LINES(64), .LATENCY(4), .CNT_W(16))
      u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
   mem_line_ctrl #(.ADDR_W(10), .LINE_W(128), .LINES(64), .LATENCY(1), .CNT_W(3))
      u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
   mem_line_ctrl #(.ADDR_W(10), .LINE_W(128), .LINES(64), .LATENCY(15), .CNT_W(16))
      u2 (.clk(clk), .rst_n(rst_n), .bus(b2));

   always #5 clk = ~clk;

   // reference: plain array of lines plus saturating counters per instance
   logic [127:0] ref_mem [3][64];
   int           ref_rd [3];
   int           ref_wr [3];
   int           ref_max [3] = '{65535, 7, 65535};
   int           ref_lat [3] = '{4, 1, 15};

   typedef struct {
      logic         rw;
      logic [9:0]   addr;
      logic [127:0] wdata;
      logic [127:0] exp_rdata;
      int           exp_rd;
      int           exp_wr;
   } vec_t;

   localparam logic [127:0] LD = 128'h00112233_44556677_8899AABB_CCDDEEFF;
   localparam logic [127:0] LE = 128'hDEADBEEF_0BADF00D_CAFEBABE_12345678;
   localparam logic [127:0] LF = {128{1'b1}};

   task automatic drv(input int d, input logic v, input logic rw, input logic [9:0] a,
                      input logic [127:0] wd, input logic rr);
      case (d)
         0: begin b0.req_valid = v; b0.req_rw = rw; b0.req_addr = a; b0.req_wdata = wd; b0.resp_ready = rr; end
         1: begin b1.req_valid = v; b1.req_rw = rw; b1.req_addr = a; b1.req_wdata = wd; b1.resp_ready = rr; end
         default: begin b2.req_valid = v; b2.req_rw = rw; b2.req_addr = a; b2.req_wdata = wd; b2.resp_ready = rr; end
      endcase
   endtask

   function automatic int get_rdy(input int d);
      case (d)
         0: return int'(b0.req_ready);
         1: return int'(b1.req_ready);
         default: return int'(b2.req_ready);
      endcase
   endfunction

   function automatic int get_vld(input int d);
      case (d)
         0: return int'(b0.resp_valid);
         1: return int'(b1.resp_valid);
         default: return int'(b2.resp_valid);
      endcase
   endfunction

   function automatic logic [127:0] get_rdata(input int d);
      case (d)
         0: return b0.resp_rdata;
         1: return b1.resp_rdata;
         default: return b2.resp_rdata;
      endcase
   endfunction

   function automatic int get_rd(input int d);
      case (d)
         0: return int'(b0.rd_count);
         1: return int'(b1.rd_count);
         default: return int'(b2.rd_count);
      endcase
   endfunction

   function automatic int get_wr(input int d);
      case (d)
         0: return int'(b0.wr_count);
         1: return int'(b1.wr_count);
         default: return int'(b2.wr_count);
      endcase
   endfunction

   task automatic chk_v(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic chk_i(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 3; d++) begin
         ref_rd[d] = 0;
         ref_wr[d] = 0;
         for (int i = 0; i < 64; i++) ref_mem[d][i] = '0;
      end
   endtask

   task automatic model(input int d, input logic rw, input logic [9:0] a,
                        input logic [127:0] wd, output logic [127:0] exp);
      int idx;
      idx = int'(a) / 16;
      if (rw) begin
         ref_mem[d][idx] = wd;
         exp = wd;
         if (ref_wr[d] < ref_max[d]) ref_wr[d] = ref_wr[d] + 1;
      end else begin
         exp = ref_mem[d][idx];
         if (ref_rd[d] < ref_max[d]) ref_rd[d] = ref_rd[d] + 1;
      end
   endtask

   // called at a negedge; returns at a negedge
   task automatic txn(input int d, input logic rw, input logic [9:0] a, input logic [127:0] wd,
                      input logic [127:0] exp, input logic rr);
      int k;
      k = 0;
      while (get_rdy(d) == 0 && k < 50) begin @(negedge clk); k++; end
      chk_i("req_ready_idle", get_rdy(d), 1);
      drv(d, 1'b1, rw, a, wd, rr);
      @(posedge clk);
      @(negedge clk);
      drv(d, 1'b0, rw, a, wd, rr);
      chk_i("req_ready_busy", get_rdy(d), 0);
      k = 0;
      while (get_vld(d) == 0 && k < 40) begin @(negedge clk); k++; end
      chk_i("latency", k, ref_lat[d]);
      chk_v("resp_rdata", get_rdata(d), exp);
      if (rr) begin
         @(negedge clk);
         chk_i("resp_valid_clear", get_vld(d), 0);
      end
   endtask

   task automatic chk_cnt(input int d);
      chk_i("rd_count", get_rd(d), ref_rd[d]);
      chk_i("wr_count", get_wr(d), ref_wr[d]);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t         tab [8];
      logic [127:0] mexp;
      logic [127:0] wd;
      logic [5:0]   idx;
      logic [3:0]   ofs;
      logic         rw;
      int           seen;

      tab[0] = '{1'b0, 10'h3A5, '0, '0, 1, 0};
      tab[1] = '{1'b1, 10'h120, LD, LD, 1, 1};
      tab[2] = '{1'b0, 10'h12F, '0, LD, 2, 1};
      tab[3] = '{1'b1, 10'h12A, LE, LE, 2, 2};
      tab[4] = '{1'b0, 10'h3A0, '0, '0, 3, 2};
      tab[5] = '{1'b0, 10'h121, '0, LE, 4, 2};
      tab[6] = '{1'b1, 10'h3FF, LF, LF, 4, 3};
      tab[7] = '{1'b0, 10'h3F0, '0, LF, 5, 3};

      n_cmp  = 0;
      n_fail = 0;
      clk    = 1'b0;
      rst_n  = 1'b0;
      for (int d = 0; d < 3; d++) drv(d, 1'b0, 1'b0, '0, '0, 1'b1);
      model_reset();
      repeat (2) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         chk_i("reset_req_ready", get_rdy(d), 0);
         chk_i("reset_resp_valid", get_vld(d), 0);
         chk_v("reset_resp_rdata", get_rdata(d), '0);
         chk_cnt(d);
      end
      rst_n = 1'b1;
      @(negedge clk);
      chk_i("ready_after_release", get_rdy(0), 1);

      for (int i = 0; i < 8; i++) begin
         model(0, tab[i].rw, tab[i].addr, tab[i].wdata, mexp);
         txn(0, tab[i].rw, tab[i].addr, tab[i].wdata, tab[i].exp_rdata, 1'b1);
         chk_i("tab_rd_count", get_rd(0), tab[i].exp_rd);
         chk_i("tab_wr_count", get_wr(0), tab[i].exp_wr);
      end

      // response stall with a spurious request that must not be taken
      model(0, 1'b0, 10'h125, '0, mexp);
      txn(0, 1'b0, 10'h125, '0, mexp, 1'b0);
      for (int i = 0; i < 10; i++) begin
         drv(0, 1'(i % 2), 1'b1, 10'h200, LF, 1'b0);
         @(negedge clk);
         chk_i("stall_valid", get_vld(0), 1);
         chk_v("stall_rdata", get_rdata(0), mexp);
         chk_i("stall_ready", get_rdy(0), 0);
      end
      drv(0, 1'b0, 1'b0, '0, '0, 1'b1);
      @(negedge clk);
      chk_i("stall_release", get_vld(0), 0);
      chk_cnt(0);

      for (int i = 0; i < 30; i++) begin
         rw  = 1'($urandom_range(0, 1));
         idx = 6'($urandom_range(0, 7));
         ofs = 4'($urandom_range(0, 15));
         wd  = {$urandom, $urandom, $urandom, $urandom};
         model(0, rw, {idx, ofs}, wd, mexp);
         txn(0, rw, {idx, ofs}, wd, mexp, 1'b1);
         chk_cnt(0);
      end

      // reset between acceptance and access drops the write
      drv(0, 1'b1, 1'b1, 10'h040, LF, 1'b1);
      @(posedge clk);
      @(negedge clk);
      drv(0, 1'b0, 1'b0, '0, '0, 1'b1);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk_i("midreset_ready", get_rdy(0), 0);
      chk_i("midreset_valid", get_vld(0), 0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      chk_cnt(0);
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         seen += get_vld(0);
      end
      chk_i("midreset_no_resp", seen, 0);
      model(0, 1'b0, 10'h040, '0, mexp);
      txn(0, 1'b0, 10'h040, '0, 128'h0, 1'b1);
      chk_cnt(0);

      // 3-bit counters on the LATENCY=1 unit saturate at 7
      for (int i = 0; i < 10; i++) begin
         idx = 6'($urandom_range(0, 63));
         wd  = {$urandom, $urandom, $urandom, $urandom};
         model(1, 1'b1, {idx, 4'h0}, wd, mexp);
         txn(1, 1'b1, {idx, 4'h0}, wd, mexp, 1'b1);
         chk_cnt(1);
      end
      chk_i("wr_count_saturated", get_wr(1), 7);
      model(1, 1'b0, {idx, 4'h9}, '0, mexp);
      txn(1, 1'b0, {idx, 4'h9}, '0, wd, 1'b1);
      chk_cnt(1);

      for (int i = 0; i < 3; i++) begin
         rw  = 1'(i != 1);
         idx = 6'($urandom_range(0, 3));
         wd  = {$urandom, $urandom, $urandom, $urandom};
         model(2, rw, {idx, 4'h3}, wd, mexp);
         txn(2, rw, {idx, 4'h3}, wd, mexp, 1'b1);
         chk_cnt(2);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
